// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, op4 codes, PSR bit
// positions, sequencer states and the op4 decode helpers.
package alu_pkg;

  localparam logic [7:0] ALU_AND  = 8'h01;
  localparam logic [7:0] ALU_OR   = 8'h02;
  localparam logic [7:0] ALU_XOR  = 8'h03;
  localparam logic [7:0] ALU_NOT  = 8'h04;
  localparam logic [7:0] ALU_ADD  = 8'h05;
  localparam logic [7:0] ALU_ADDU = 8'h06;
  localparam logic [7:0] ALU_ADDC = 8'h07;
  localparam logic [7:0] ALU_SUB  = 8'h09;
  localparam logic [7:0] ALU_CMP  = 8'h0B;
  localparam logic [7:0] ALU_LSH  = 8'h84;
  localparam logic [7:0] ALU_RSH  = 8'h08;
  localparam logic [7:0] ALU_ALSH = 8'h0C;
  localparam logic [7:0] ALU_ARSH = 8'h0F;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDU = 4'h5;
  localparam logic [3:0] OP_ADDC = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_LSH  = 4'h9;
  localparam logic [3:0] OP_RSH  = 4'hA;
  localparam logic [3:0] OP_ALSH = 4'hB;
  localparam logic [3:0] OP_ARSH = 4'hC;

  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_L = 2;
  localparam int unsigned PSR_F = 5;
  localparam int unsigned PSR_Z = 6;
  localparam int unsigned PSR_N = 7;
  localparam logic [7:0]  PSR_MASK = 8'hE5;

  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_e;

  function automatic logic op_legal(input logic [3:0] op4);
    return op4 <= OP_ARSH;
  endfunction

  function automatic logic op_is_shift(input logic [3:0] op4);
    return (op4 >= OP_LSH) && (op4 <= OP_ARSH);
  endfunction

  function automatic logic [7:0] op_decode(input logic [3:0] op4);
    logic [7:0] opc;
    case (op4)
      OP_AND:  opc = ALU_AND;
      OP_OR:   opc = ALU_OR;
      OP_XOR:  opc = ALU_XOR;
      OP_NOT:  opc = ALU_NOT;
      OP_ADD:  opc = ALU_ADD;
      OP_ADDU: opc = ALU_ADDU;
      OP_ADDC: opc = ALU_ADDC;
      OP_SUB:  opc = ALU_SUB;
      OP_CMP:  opc = ALU_CMP;
      OP_LSH:  opc = ALU_LSH;
      OP_RSH:  opc = ALU_RSH;
      OP_ALSH: opc = ALU_ALSH;
      OP_ARSH: opc = ALU_ARSH;
      default: opc = 8'h00;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Next-PSR computation from the operands presented to the ALU. Ops that do not
// own any flag pass the old PSR through.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [15:0] r1_i,
  input  logic [15:0] r2_i,
  input  logic [7:0]  opcode_i,
  input  logic        carry_in_i,
  input  logic [7:0]  psr_i,
  output logic [7:0]  psr_o
);

  logic [16:0] sum;

  always_comb begin
    psr_o = psr_i & PSR_MASK;
    sum   = '0;
    case (opcode_i)
      ALU_ADD, ALU_ADDC: begin
        sum = {1'b0, r1_i} + {1'b0, r2_i}
            + {16'b0, carry_in_i && (opcode_i == ALU_ADDC)};
        psr_o[PSR_C] = sum[16];
        psr_o[PSR_F] = (r1_i[15] == r2_i[15]) && (sum[15] != r1_i[15]);
      end
      ALU_SUB: begin
        sum = {1'b0, r1_i} + {1'b0, ~r2_i} + 17'd1;
        psr_o[PSR_C] = sum[16];
        psr_o[PSR_F] = (r1_i[15] != r2_i[15]) && (sum[15] != r1_i[15]);
      end
      ALU_CMP: begin
        psr_o[PSR_Z] = (r1_i == r2_i);
        psr_o[PSR_L] = (r1_i < r2_i);
        psr_o[PSR_N] = ($signed(r1_i) < $signed(r2_i));
        psr_o[PSR_C] = 1'b0;
        psr_o[PSR_F] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Four-state issue controller: IDLE -> RD -> EX -> WB. Define ALU_SEQ_IMM_EN to let
// mode[3] replace the rs operand with the 4-bit immediate instr[7:4].
module alu_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic [15:0] alu_r1,
  output logic [15:0] alu_r2,
  output logic [7:0]  alu_opcode,
  input  logic [15:0] alu_rout,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [7:0]  psr,
  output logic        done,
  output logic        err
);

  state_e      state_q;
  logic [3:0]  op4_q, rd_q, rs_q, waddr_q;
  logic        imm_q;
  logic [15:0] r1_q, r2_q, wdata_q;
  logic [7:0]  opcode_q, psr_q;
  logic        we_q, done_q, err_q;

  logic        legal, shift;
  logic [15:0] opnd_b, ex_r1, ex_r2;
  logic [7:0]  psr_nxt;
  logic        unused_mode;

  assign legal = op_legal(op4_q);
  assign shift = op_is_shift(op4_q);

`ifdef ALU_SEQ_IMM_EN
  assign opnd_b      = imm_q ? {12'b0, rs_q} : rf_rdata_b;
  assign unused_mode = ^instr[2:0];
`else
  assign opnd_b      = rf_rdata_b;
  assign unused_mode = ^{instr[2:0], imm_q};
`endif

  // Shifts take the amount in r1 and the value in r2, hence the swap.
  assign ex_r1 = shift ? opnd_b : rf_rdata_a;
  assign ex_r2 = shift ? rf_rdata_a : opnd_b;

  alu_flag_gen u_flag_gen (
    .r1_i       (ex_r1),
    .r2_i       (ex_r2),
    .opcode_i   (opcode_q),
    .carry_in_i (psr_q[PSR_C]),
    .psr_i      (psr_q),
    .psr_o      (psr_nxt)
  );

  // Read data only arrives in EX, so operands bypass the hold register there.
  assign alu_r1      = (state_q == EX && legal) ? ex_r1 : r1_q;
  assign alu_r2      = (state_q == EX && legal) ? ex_r2 : r2_q;
  assign alu_opcode  = opcode_q;
  assign instr_ready = (state_q == IDLE);
  assign rf_raddr_a  = rd_q;
  assign rf_raddr_b  = rs_q;
  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign psr         = psr_q;
  assign done        = done_q;
  assign err         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op4_q    <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      imm_q    <= 1'b0;
      r1_q     <= '0;
      r2_q     <= '0;
      opcode_q <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      psr_q    <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            op4_q   <= instr[15:12];
            rd_q    <= instr[11:8];
            rs_q    <= instr[7:4];
            imm_q   <= instr[3];
            state_q <= RD;
          end
        end
        RD: begin
          if (legal) opcode_q <= op_decode(op4_q);
          state_q <= EX;
        end
        EX: begin
          if (legal) begin
            r1_q    <= ex_r1;
            r2_q    <= ex_r2;
            waddr_q <= rd_q;
            wdata_q <= alu_rout;
            we_q    <= (op4_q != OP_CMP);
            psr_q   <= psr_nxt;
            done_q  <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= WB;
        end
        WB:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural register file and ALU, instruction-level model
// feeding an expected-result queue popped as each instruction retires.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, alu_r1, alu_r2, alu_rout, rf_wdata;
  logic [7:0]  alu_opcode, psr;
  logic        rf_we, done, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .alu_r1      (alu_r1),
    .alu_r2      (alu_r2),
    .alu_opcode  (alu_opcode),
    .alu_rout    (alu_rout),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .psr         (psr),
    .done        (done),
    .err         (err)
  );

  // Register file with registered read ports and a bench-side preload path.
  logic [15:0] rf [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clk) begin
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  always_comb begin
    alu_rout = 16'h0000;
    case (alu_opcode)
      8'h01:               alu_rout = alu_r1 & alu_r2;
      8'h02:               alu_rout = alu_r1 | alu_r2;
      8'h03:               alu_rout = alu_r1 ^ alu_r2;
      8'h04:               alu_rout = ~alu_r1;
      8'h05, 8'h06, 8'h07: alu_rout = alu_r1 + alu_r2;
      8'h09, 8'h0B:        alu_rout = alu_r1 - alu_r2;
      8'h84, 8'h0C:        alu_rout = alu_r2 << alu_r1[3:0];
      8'h08:               alu_rout = alu_r2 >> alu_r1[3:0];
      8'h0F:               alu_rout = 16'($signed(alu_r2) >>> alu_r1[3:0]);
      default:             alu_rout = 16'h0000;
    endcase
  end

  typedef struct packed {
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [7:0]  psr;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        ready;
    logic        we_early;
    logic [3:0]  lat;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [7:0]  psr;
    logic        err;
    logic [7:0]  ex_opc;
  } obs_t;

  logic [15:0] mdl_rf [16];
  logic [7:0]  mdl_psr = 8'h00;
  exp_t        exp_q [$];
  longint      t_acc;

  task automatic push_expected(input logic [15:0] ins);
    logic [3:0]  op, rd, rs;
    logic [15:0] a, b, res;
    logic        cin;
    int          s, ss, sa, sb;
    exp_t        e;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4];
    a = mdl_rf[rd]; b = mdl_rf[rs];
`ifdef ALU_SEQ_IMM_EN
    if (ins[3]) b = {12'h000, rs};
`endif
    sa = $signed(a); sb = $signed(b);
    cin = mdl_psr[0];
    e.we = 1'b0; e.waddr = rd; e.wdata = '0; e.psr = mdl_psr; e.err = 1'b0;
    res = '0;
    case (op)
      4'h0: res = a & b;
      4'h1: res = a | b;
      4'h2: res = a ^ b;
      4'h3: res = ~a;
      4'h4, 4'h6: begin
        res = a + b;
        s   = int'(a) + int'(b) + ((op == 4'h6) ? int'(cin) : 0);
        ss  = sa + sb + ((op == 4'h6) ? int'(cin) : 0);
        e.psr[0] = (s > 65535);
        e.psr[5] = (ss > 32767) || (ss < -32768);
      end
      4'h5: res = a + b;
      4'h7: begin
        res = a - b;
        ss  = sa - sb;
        e.psr[0] = (a >= b);
        e.psr[5] = (ss > 32767) || (ss < -32768);
      end
      4'h8: begin
        res = a - b;
        e.psr[6] = (a == b);
        e.psr[2] = (a < b);
        e.psr[7] = (sa < sb);
        e.psr[0] = 1'b0;
        e.psr[5] = 1'b0;
      end
      4'h9, 4'hB: res = a << b[3:0];
      4'hA:       res = a >> b[3:0];
      4'hC:       res = 16'($signed(a) >>> b[3:0]);
      default:    e.err = 1'b1;
    endcase
    if (!e.err) begin
      e.wdata = res;
      e.we    = (op != 4'h8);
      if (e.we) mdl_rf[rd] = res;
      mdl_psr = e.psr;
    end
    exp_q.push_back(e);
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [15:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = idx; pre_data = val;
    mdl_rf[idx] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one instruction, scrambles instr after the accept edge, waits for retirement.
  task automatic run_instr(input logic [15:0] ins, output obs_t o);
    o = '0;
    @(negedge clk);
    o.ready = instr_ready;
    instr = ins; instr_valid = 1'b1;
    push_expected(ins);
    @(posedge clk);
    t_acc = $time;
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) o.ex_opc = alu_opcode;
      if (done || err) begin
        o.lat = 4'(k); o.we = rf_we; o.waddr = rf_waddr; o.wdata = rf_wdata;
        o.psr = psr; o.err = err;
        break;
      end
      if (rf_we) o.we_early = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({instr_ready, rf_we, done, err} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 1000", {instr_ready, rf_we, done, err});
    end
    checks++;
    if (psr !== 8'h00) begin errors++; $display("FAIL reset_psr: got %h want 00", psr); end
    checks++;
    if ({rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, alu_r1, alu_r2, alu_opcode} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h %h %h %h %h %h %h want all 0", rf_raddr_a,
                         rf_raddr_b, rf_waddr, rf_wdata, alu_r1, alu_r2, alu_opcode);
    end
  endtask

  task automatic test_add();
    obs_t o; exp_t e;
    set_reg(4'd1, 16'hFFFF); set_reg(4'd2, 16'h0001);
    run_instr(16'h4120, o); e = exp_q.pop_front();
    checks++;
    if (o.lat !== 4'd3) begin errors++; $display("FAIL add_latency: got %0d want 3", o.lat); end
    checks++;
    if (o.we !== 1'b1 || o.waddr !== 4'h1) begin
      errors++; $display("FAIL add_we: got we=%b waddr=%h want we=1 waddr=1", o.we, o.waddr);
    end
    checks++;
    if (o.wdata !== e.wdata || o.wdata !== 16'h0000) begin
      errors++; $display("FAIL add_wdata: got %h want 0000", o.wdata);
    end
    checks++;
    if (o.psr !== e.psr || o.psr !== 8'h01) begin
      errors++; $display("FAIL add_psr: got %h want 01", o.psr);
    end
  endtask

  task automatic test_overflow();
    obs_t o; exp_t e;
    set_reg(4'd3, 16'h7FFF); set_reg(4'd4, 16'h0001);
    run_instr(16'h4340, o); e = exp_q.pop_front();
    checks++;
    if (o.wdata !== e.wdata || o.wdata !== 16'h8000 || o.we !== 1'b1) begin
      errors++; $display("FAIL ovf_wdata: got we=%b %h want we=1 8000", o.we, o.wdata);
    end
    checks++;
    if (o.psr !== e.psr || o.psr !== 8'h20) begin
      errors++; $display("FAIL ovf_psr: got %h want 20", o.psr);
    end
    set_reg(4'd10, 16'h0000); set_reg(4'd11, 16'h0000);
    run_instr(16'h6AB0, o); e = exp_q.pop_front();
    checks++;
    if (o.wdata !== e.wdata || o.wdata !== 16'h0000 || o.psr !== 8'h00) begin
      errors++; $display("FAIL addc_zero: got %h psr %h want 0000 psr 00", o.wdata, o.psr);
    end
  endtask

  task automatic test_cmp();
    obs_t o; exp_t e;
    set_reg(4'd5, 16'h0003); set_reg(4'd6, 16'hFFFE);
    run_instr(16'h8560, o); e = exp_q.pop_front();
    checks++;
    if (o.we !== 1'b0 || o.we_early !== 1'b0 || o.lat !== 4'd3 || o.err !== 1'b0) begin
      errors++; $display("FAIL cmp_nowrite: got we=%b early=%b lat=%0d err=%b want 0 0 3 0",
                         o.we, o.we_early, o.lat, o.err);
    end
    checks++;
    if (o.psr !== e.psr || o.psr !== 8'h04) begin
      errors++; $display("FAIL cmp_lt_psr: got %h want 04", o.psr);
    end
    set_reg(4'd12, 16'h1234); set_reg(4'd13, 16'h1234);
    run_instr(16'h8CD0, o); e = exp_q.pop_front();
    checks++;
    if (o.psr !== e.psr || o.psr !== 8'h40) begin
      errors++; $display("FAIL cmp_eq_psr: got %h want 40", o.psr);
    end
  endtask

  task automatic test_shift();
    obs_t o; exp_t e;
    set_reg(4'd7, 16'h0001); set_reg(4'd8, 16'h0004);
    run_instr(16'h9780, o); e = exp_q.pop_front();
    checks++;
    if (o.ex_opc !== 8'h84) begin
      errors++; $display("FAIL lsh_opcode: got %h want 84", o.ex_opc);
    end
    checks++;
    if (o.wdata !== e.wdata || o.wdata !== 16'h0010 || o.waddr !== 4'h7 || o.we !== 1'b1) begin
      errors++; $display("FAIL lsh_result: got we=%b r%0d=%h want we=1 r7=0010",
                         o.we, o.waddr, o.wdata);
    end
    checks++;
    if (o.psr !== 8'h40) begin errors++; $display("FAIL lsh_psr: got %h want 40", o.psr); end
  endtask

  task automatic test_illegal();
    obs_t o; exp_t e;
    run_instr(16'hE120, o); e = exp_q.pop_front();
    checks++;
    if (o.lat !== 4'd3 || o.err !== 1'b1 || e.err !== 1'b1) begin
      errors++; $display("FAIL illegal_err: got lat=%0d err=%b want lat=3 err=1", o.lat, o.err);
    end
    checks++;
    if (o.we !== 1'b0 || o.we_early !== 1'b0 || o.psr !== 8'h40) begin
      errors++; $display("FAIL illegal_side: got we=%b psr=%h want we=0 psr=40", o.we, o.psr);
    end
  endtask

  task automatic test_reset_inflight();
    logic saw_we;
    set_reg(4'd1, 16'h1111); set_reg(4'd2, 16'h0001);
    @(negedge clk);
    instr = 16'h4120; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    saw_we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rf_we) saw_we = 1'b1;
    end
    rst_n = 1'b1;
    mdl_psr = 8'h00;
    @(negedge clk);
    if (rf_we) saw_we = 1'b1;
    checks++;
    if (saw_we !== 1'b0 || rf[1] !== 16'h1111) begin
      errors++; $display("FAIL rst_drop: got we_seen=%b r1=%h want 0 1111", saw_we, rf[1]);
    end
    checks++;
    if (psr !== 8'h00 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL rst_state: got psr=%h ready=%b want 00 1", psr, instr_ready);
    end
  endtask

`ifdef ALU_SEQ_IMM_EN
  task automatic test_imm();
    obs_t o; exp_t e;
    set_reg(4'd9, 16'h0010); set_reg(4'd3, 16'h0100);
    run_instr(16'h7938, o); e = exp_q.pop_front();
    checks++;
    if (o.wdata !== e.wdata || o.wdata !== 16'h000D || o.psr !== 8'h01) begin
      errors++; $display("FAIL imm_sub: got %h psr %h want 000D psr 01", o.wdata, o.psr);
    end
  endtask
`endif

  task automatic test_back_to_back();
    obs_t   o; exp_t e;
    longint t_prev;
    for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom));
    t_prev = 0;
    for (int n = 0; n < 24; n++) begin
      run_instr(16'($urandom), o);
      e = exp_q.pop_front();
      checks++;
      if (o.ready !== 1'b1 || o.lat !== 4'd3 || o.err !== e.err || o.we !== e.we
          || o.psr !== e.psr || (e.we && (o.wdata !== e.wdata || o.waddr !== e.waddr))) begin
        errors++;
        $display("FAIL b2b_%0d: got rdy=%b lat=%0d err=%b we=%b r%0d=%h psr=%h want err=%b we=%b r%0d=%h psr=%h",
                 n, o.ready, o.lat, o.err, o.we, o.waddr, o.wdata, o.psr,
                 e.err, e.we, e.waddr, e.wdata, e.psr);
      end
      if (n > 0) begin
        checks++;
        if (t_acc - t_prev != 40) begin
          errors++; $display("FAIL b2b_rate_%0d: got %0d want 40 time units", n, t_acc - t_prev);
        end
      end
      t_prev = t_acc;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom));
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_add();
    test_overflow();
    test_cmp();
    test_shift();
    test_illegal();
    test_reset_inflight();
`ifdef ALU_SEQ_IMM_EN
    test_imm();
`endif
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left: got %0d want 0 entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
